vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/crtc_pkg.sv | 19 +
 rtl/vram_arbiter_if.sv | 28 ++
 rtl/vram_slot_window.sv | 26 ++
 rtl/vram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crtc_pkg.sv
// Shared types and constants for the character-cell VRAM arbiter.
package crtc_pkg;

  localparam int VRAM_ADDR_W = 11;
  localparam int VRAM_DATA_W = 8;
  localparam int PIX_PHASES  = 10;

  localparam int DEF_CPU_SLOT_FIRST = 7;
  localparam int DEF_CPU_SLOT_LAST  = 8;
  localparam int DEF_CRTC_CAPTURE   = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU request bus and VRAM device pins seen by the arbiter.
// master = CPU plus memory side, slave = arbiter.
interface vram_arbiter_if;

  logic                             cpu_req;
  logic                             cpu_we;
  logic [crtc_pkg::VRAM_ADDR_W-1:0] cpu_address;
  logic [crtc_pkg::VRAM_DATA_W-1:0] cpu_wdata;
  logic                             cpu_ack;
  logic [crtc_pkg::VRAM_DATA_W-1:0] cpu_rdata;

  logic [crtc_pkg::VRAM_ADDR_W-1:0] vram_addr;
  logic [crtc_pkg::VRAM_DATA_W-1:0] vram_wdata;
  logic [crtc_pkg::VRAM_DATA_W-1:0] vram_rdata;
  logic                             vram_n_we;
  logic                             vram_n_oe;

  modport master (
    output cpu_req, cpu_we, cpu_address, cpu_wdata, vram_rdata,
    input  cpu_ack, cpu_rdata, vram_addr, vram_wdata, vram_n_we, vram_n_oe
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_address, cpu_wdata, vram_rdata,
    output cpu_ack, cpu_rdata, vram_addr, vram_wdata, vram_n_we, vram_n_oe
  );

endinterface

// File: rtl/vram_slot_window.sv
// Decides whether a CPU access may start in the current character pixel phase.
module vram_slot_window
  import crtc_pkg::*;
#(
  parameter int CPU_SLOT_FIRST = DEF_CPU_SLOT_FIRST,
  parameter int CPU_SLOT_LAST  = DEF_CPU_SLOT_LAST
) (
  input  logic [3:0] char_pix_count,
  input  logic       display_active,
  output logic       window_open
);

  localparam logic [3:0] FIRST_C      = 4'(CPU_SLOT_FIRST);
  localparam logic [3:0] LAST_C       = 4'(CPU_SLOT_LAST);
  localparam logic [3:0] LAST_PHASE_C = 4'(PIX_PHASES - 1);

  logic in_slot;

  // Phases 10..15 never occur in a healthy timing chain, so they count as closed.
  always_comb begin
    in_slot     = (char_pix_count >= FIRST_C) && (char_pix_count <= LAST_C) &&
                  (char_pix_count <= LAST_PHASE_C);
    window_open = !display_active || in_slot;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one VRAM between CRTC fetches and CPU accesses (SETUP/STROBE/DONE).
// Optional single-entry posted-write buffer: VRAM_ARB_WRITE_BUFFER_EN.
module vram_arbiter
  import crtc_pkg::*;
#(
  parameter int CPU_SLOT_FIRST = DEF_CPU_SLOT_FIRST,
  parameter int CPU_SLOT_LAST  = DEF_CPU_SLOT_LAST,
  parameter int CRTC_CAPTURE   = DEF_CRTC_CAPTURE
) (
  input  logic                   pixel_clk,
  input  logic                   n_reset,
  input  logic [3:0]             char_pix_count,
  input  logic                   display_active,
  input  logic [VRAM_ADDR_W-1:0] crtc_address,
  output logic [VRAM_DATA_W-1:0] crtc_data,
  vram_arbiter_if.slave          bus
);

  localparam logic [3:0] CAPTURE_PHASE = 4'(CRTC_CAPTURE);

  arb_state_e             state_q, state_d;
  logic                   window_open;
  logic                   start_access;
  logic                   access_write;
  logic [VRAM_ADDR_W-1:0] access_addr;
  logic [VRAM_DATA_W-1:0] access_data;
  logic                   access_ack;
  logic [VRAM_DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [VRAM_DATA_W-1:0] crtc_data_q, crtc_data_d;

  vram_slot_window #(
    .CPU_SLOT_FIRST (CPU_SLOT_FIRST),
    .CPU_SLOT_LAST  (CPU_SLOT_LAST)
  ) u_slot_window (
    .char_pix_count (char_pix_count),
    .display_active (display_active),
    .window_open    (window_open)
  );

`ifdef VRAM_ARB_WRITE_BUFFER_EN
  logic                   buf_valid_q, buf_valid_d;
  logic [VRAM_ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [VRAM_DATA_W-1:0] buf_data_q, buf_data_d;
  logic                   post_ack_q, post_ack_d;
  logic                   drain_q, drain_d;

  // A pending posted write always drains before any CPU read is allowed to start.
  always_comb begin
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    post_ack_d   = 1'b0;
    drain_d      = drain_q;
    start_access = 1'b0;

    if (state_q == IDLE && window_open) begin
      if (buf_valid_q) begin
        start_access = 1'b1;
        drain_d      = 1'b1;
      end else if (bus.cpu_req && !bus.cpu_we) begin
        start_access = 1'b1;
        drain_d      = 1'b0;
      end
    end

    if (bus.cpu_req && bus.cpu_we && !buf_valid_q && !post_ack_q) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = bus.cpu_address;
      buf_data_d  = bus.cpu_wdata;
      post_ack_d  = 1'b1;
    end

    if (state_q == DONE && drain_q) begin
      buf_valid_d = 1'b0;
    end

    access_write = drain_q;
    access_addr  = drain_q ? buf_addr_q : bus.cpu_address;
    access_data  = drain_q ? buf_data_q : bus.cpu_wdata;
    access_ack   = post_ack_q || (state_q == DONE && !drain_q);
  end

  always_ff @(posedge pixel_clk or negedge n_reset) begin
    if (!n_reset) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      post_ack_q  <= 1'b0;
      drain_q     <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      post_ack_q  <= post_ack_d;
      drain_q     <= drain_d;
    end
  end
`else
  always_comb begin
    start_access = (state_q == IDLE) && bus.cpu_req && window_open;
    access_write = bus.cpu_we;
    access_addr  = bus.cpu_address;
    access_data  = bus.cpu_wdata;
    access_ack   = (state_q == DONE);
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_access) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // IDLE hands the bus to the CRTC; read data is captured as the strobe ends.
  always_comb begin
    bus.vram_addr  = crtc_address;
    bus.vram_wdata = '0;
    bus.vram_n_we  = 1'b1;
    bus.vram_n_oe  = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    crtc_data_d    = crtc_data_q;

    case (state_q)
      SETUP, DONE: begin
        bus.vram_addr  = access_addr;
        bus.vram_wdata = access_data;
        bus.vram_n_oe  = 1'b1;
      end
      STROBE: begin
        bus.vram_addr  = access_addr;
        bus.vram_wdata = access_data;
        bus.vram_n_we  = !access_write;
        bus.vram_n_oe  = access_write;
        if (!access_write) cpu_rdata_d = bus.vram_rdata;
      end
      default: ;
    endcase

    if (display_active && char_pix_count == CAPTURE_PHASE) begin
      crtc_data_d = bus.vram_rdata;
    end
  end

  always_ff @(posedge pixel_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      cpu_rdata_q <= '0;
      crtc_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cpu_rdata_q <= cpu_rdata_d;
      crtc_data_q <= crtc_data_d;
    end
  end

  assign bus.cpu_ack   = access_ack;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign crtc_data     = crtc_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter; phases count 0..9 and a "phase k" cycle is
// the clock period during which char_pix_count == k.
module tb_vram_arbiter;
  import crtc_pkg::*;

  logic                   pixel_clk = 1'b0;
  logic                   n_reset;
  logic [3:0]             char_pix_count;
  logic                   display_active;
  logic                   phase_run;
  logic [VRAM_ADDR_W-1:0] crtc_address;
  logic [VRAM_DATA_W-1:0] crtc_data;

  int vectors     = 0;
  int miscompares = 0;
  int watch_viol  = 0;

`ifdef VRAM_ARB_WRITE_BUFFER_EN
  localparam int EXP_WR_LAT = 1;
`else
  localparam int EXP_WR_LAT = 3;
`endif

  vram_arbiter_if bus_if ();

  vram_arbiter dut (
    .pixel_clk      (pixel_clk),
    .n_reset        (n_reset),
    .char_pix_count (char_pix_count),
    .display_active (display_active),
    .crtc_address   (crtc_address),
    .crtc_data      (crtc_data),
    .bus            (bus_if)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge pixel_clk);
    #1;
    if (phase_run) char_pix_count = (char_pix_count >= 4'd9) ? 4'd0 : char_pix_count + 4'd1;
    #1;
  endtask

  task automatic step_watch();
    step();
    if (display_active && char_pix_count >= 4'd2 && char_pix_count <= 4'd6 &&
        !(bus_if.vram_n_we === 1'b1 && bus_if.vram_n_oe === 1'b0 && bus_if.vram_addr === crtc_address))
      watch_viol++;
  endtask

  task automatic cpu_idle();
    bus_if.cpu_req     = 1'b0;
    bus_if.cpu_we      = 1'b0;
    bus_if.cpu_address = '0;
    bus_if.cpu_wdata   = '0;
  endtask

  task automatic cpu_issue(input logic we, input logic [10:0] addr, input logic [7:0] data);
    bus_if.cpu_req     = 1'b1;
    bus_if.cpu_we      = we;
    bus_if.cpu_address = addr;
    bus_if.cpu_wdata   = data;
  endtask

  task automatic wait_phase(input logic [3:0] p);
    int n = 0;
    while (char_pix_count !== p && n < 30) begin
      step();
      n++;
    end
    vectors++;
    if (char_pix_count !== p) begin
      miscompares++;
      $display("[TB] FAIL wait_phase: phase=%0d required=%0d", char_pix_count, p);
    end
  endtask

  task automatic settle();
    cpu_idle();
    display_active = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_reset();
    n_reset = 1'b0; phase_run = 1'b0; char_pix_count = 4'd0; display_active = 1'b0;
    crtc_address = 11'h3C0; bus_if.vram_rdata = 8'h00;
    cpu_idle();
    #3;
    vectors++; if (bus_if.cpu_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cpu_ack: got=%b want=0", bus_if.cpu_ack); end
    vectors++; if (bus_if.cpu_rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_cpu_rdata: got=%h want=00", bus_if.cpu_rdata); end
    vectors++; if (crtc_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_crtc_data: got=%h want=00", crtc_data); end
    vectors++; if (bus_if.vram_n_we !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_n_we: got=%b want=1", bus_if.vram_n_we); end
    vectors++; if (bus_if.vram_n_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_n_oe: got=%b want=0", bus_if.vram_n_oe); end
    vectors++; if (bus_if.vram_wdata !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_wdata: got=%h want=00", bus_if.vram_wdata); end
    vectors++; if (bus_if.vram_addr !== 11'h3C0) begin miscompares++; $display("[TB] FAIL reset_addr: got=%h want=3c0", bus_if.vram_addr); end
    repeat (2) step();
    n_reset = 1'b1;
    phase_run = 1'b1;
    step();
  endtask

  task automatic test_write_idle();
    int ack_lat = 0, ack_cnt = 0, low_cnt = 0;
    logic [10:0] low_addr = '0;
    logic [7:0]  low_data = '0;
    settle();
    cpu_issue(1'b1, 11'h123, 8'h5A);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus_if.vram_n_we === 1'b0) begin
        low_cnt++;
        low_addr = bus_if.vram_addr;
        low_data = bus_if.vram_wdata;
      end
      if (bus_if.cpu_ack === 1'b1) begin
        ack_cnt++;
        if (ack_lat == 0) ack_lat = i;
        cpu_idle();
      end
    end
    vectors++; if (ack_lat != EXP_WR_LAT) begin miscompares++; $display("[TB] FAIL wr_ack_latency: got=%0d want=%0d", ack_lat, EXP_WR_LAT); end
    vectors++; if (ack_cnt != 1) begin miscompares++; $display("[TB] FAIL wr_ack_width: got=%0d want=1", ack_cnt); end
    vectors++; if (low_cnt != 1) begin miscompares++; $display("[TB] FAIL wr_n_we_cycles: got=%0d want=1", low_cnt); end
    vectors++; if (low_addr !== 11'h123) begin miscompares++; $display("[TB] FAIL wr_strobe_addr: got=%h want=123", low_addr); end
    vectors++; if (low_data !== 8'h5A) begin miscompares++; $display("[TB] FAIL wr_strobe_data: got=%h want=5a", low_data); end
  endtask

  task automatic test_read_window();
    int          req_ph[3]     = '{3, 8, 9};
    int          exp_setup[3]  = '{8, 9, 8};
    int          exp_strobe[3] = '{9, 0, 9};
    int          exp_ack[3]    = '{0, 1, 0};
    logic [10:0] addrs[3]      = '{11'h2A5, 11'h155, 11'h7FF};
    logic [7:0]  rdv[3]        = '{8'h96, 8'h3C, 8'hE1};
    int setup_ph, strobe_ph, ack_ph, strobes;
    settle();
    display_active = 1'b1;
    for (int e = 0; e < 3; e++) begin
      wait_phase(4'(req_ph[e]));
      cpu_issue(1'b0, addrs[e], 8'h00);
      bus_if.vram_rdata = rdv[e];
      setup_ph = -1; strobe_ph = -1; ack_ph = -1; strobes = 0;
      for (int c = 0; c < 30 && ack_ph < 0; c++) begin
        step();
        if (bus_if.vram_addr === addrs[e] && bus_if.vram_n_oe === 1'b1 && bus_if.vram_n_we === 1'b1 && setup_ph < 0)
          setup_ph = int'(char_pix_count);
        if (bus_if.vram_addr === addrs[e] && bus_if.vram_n_oe === 1'b0) begin
          strobes++;
          strobe_ph = int'(char_pix_count);
        end
        if (bus_if.cpu_ack === 1'b1) begin
          ack_ph = int'(char_pix_count);
          cpu_idle();
        end
      end
      step();
      vectors++; if (setup_ph != exp_setup[e]) begin miscompares++; $display("[TB] FAIL rd%0d_setup_phase: got=%0d want=%0d", e, setup_ph, exp_setup[e]); end
      vectors++; if (strobe_ph != exp_strobe[e]) begin miscompares++; $display("[TB] FAIL rd%0d_strobe_phase: got=%0d want=%0d", e, strobe_ph, exp_strobe[e]); end
      vectors++; if (strobes != 1) begin miscompares++; $display("[TB] FAIL rd%0d_strobe_cycles: got=%0d want=1", e, strobes); end
      vectors++; if (ack_ph != exp_ack[e]) begin miscompares++; $display("[TB] FAIL rd%0d_ack_phase: got=%0d want=%0d", e, ack_ph, exp_ack[e]); end
      vectors++; if (bus_if.cpu_rdata !== rdv[e]) begin miscompares++; $display("[TB] FAIL rd%0d_rdata: got=%h want=%h", e, bus_if.cpu_rdata, rdv[e]); end
    end
  endtask

  task automatic test_crtc_capture();
    settle();
    display_active = 1'b1;
    bus_if.vram_rdata = 8'h42;
    wait_phase(4'd6);
    step();
    vectors++; if (crtc_data !== 8'h42) begin miscompares++; $display("[TB] FAIL crtc_first_capture: got=%h want=42", crtc_data); end
    wait_phase(4'd5);
    bus_if.vram_rdata = 8'hC3;
    step();
    vectors++; if (crtc_data !== 8'h42) begin miscompares++; $display("[TB] FAIL crtc_no_capture_ph5: got=%h want=42", crtc_data); end
    step();
    vectors++; if (crtc_data !== 8'hC3) begin miscompares++; $display("[TB] FAIL crtc_capture_ph6: got=%h want=c3", crtc_data); end
    bus_if.vram_rdata = 8'h5E;
    step();
    vectors++; if (crtc_data !== 8'hC3) begin miscompares++; $display("[TB] FAIL crtc_hold_ph7: got=%h want=c3", crtc_data); end
    wait_phase(4'd6);
    display_active = 1'b0;
    bus_if.vram_rdata = 8'h77;
    step();
    vectors++; if (crtc_data !== 8'hC3) begin miscompares++; $display("[TB] FAIL crtc_hold_blank: got=%h want=c3", crtc_data); end
  endtask

  task automatic test_closed_phase();
    int bad = 0;
    settle();
    phase_run = 1'b0;
    display_active = 1'b1;
    for (int v = 10; v <= 15; v++) begin
      char_pix_count = 4'(v);
      cpu_issue(1'b0, 11'h0AA, 8'h00);
      repeat (3) begin
        step();
        if (!(bus_if.vram_n_oe === 1'b0 && bus_if.vram_n_we === 1'b1 &&
              bus_if.vram_addr === crtc_address && bus_if.cpu_ack === 1'b0)) bad++;
      end
    end
    vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL closed_phase_start: bad_cycles=%0d want=0", bad); end
    cpu_idle();
    char_pix_count = 4'd0;
    phase_run = 1'b1;
  endtask

  task automatic test_reset_strobe();
    int found = 0, bad = 0;
    settle();
    cpu_issue(1'b1, 11'h0F0, 8'hA5);
    for (int i = 0; i < 8 && found == 0; i++) begin
      step();
      if (bus_if.vram_n_we === 1'b0) found = 1;
    end
    vectors++; if (found != 1) begin miscompares++; $display("[TB] FAIL rst_reach_strobe: got=%0d want=1", found); end
    #1 n_reset = 1'b0;
    #1;
    vectors++; if (bus_if.vram_n_we !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_strobe_n_we: got=%b want=1", bus_if.vram_n_we); end
    vectors++; if (bus_if.cpu_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_strobe_ack: got=%b want=0", bus_if.cpu_ack); end
    cpu_idle();
    repeat (2) step();
    n_reset = 1'b1;
    repeat (3) begin
      step();
      if (!(bus_if.vram_n_oe === 1'b0 && bus_if.vram_n_we === 1'b1 &&
            bus_if.vram_addr === crtc_address && bus_if.cpu_ack === 1'b0)) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL rst_release_idle: bad_cycles=%0d want=0", bad); end
  endtask

  task automatic test_no_strobe_random();
    int timeouts = 0;
    logic acked;
    settle();
    display_active = 1'b1;
    watch_viol = 0;
    for (int r = 0; r < 1000; r++) begin
      repeat ($urandom_range(0, 3)) step_watch();
      cpu_issue(1'($urandom_range(0, 1)), 11'($urandom_range(0, 959)), 8'($urandom_range(0, 255)));
      bus_if.vram_rdata = 8'($urandom_range(0, 255));
      acked = 1'b0;
      for (int c = 0; c < 40 && !acked; c++) begin
        step_watch();
        if (bus_if.cpu_ack === 1'b1) begin
          acked = 1'b1;
          cpu_idle();
        end
      end
      if (!acked) begin
        timeouts++;
        cpu_idle();
      end
    end
    repeat (12) step_watch();
    vectors++; if (watch_viol != 0) begin miscompares++; $display("[TB] FAIL no_strobe_ph2_6: violations=%0d want=0", watch_viol); end
    vectors++; if (timeouts != 0) begin miscompares++; $display("[TB] FAIL random_ack_timeout: timeouts=%0d want=0", timeouts); end
  endtask

`ifdef VRAM_ARB_WRITE_BUFFER_EN
  task automatic test_back_to_back();
    int s1_ph = -1, s2_ph = -1, ack2_ph = -1, ack2_after_s1 = 0;
    settle();
    display_active = 1'b1;
    wait_phase(4'd2);
    cpu_issue(1'b1, 11'h010, 8'h11);
    step();
    vectors++; if (bus_if.cpu_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_first_ack: got=%b want=1", bus_if.cpu_ack); end
    cpu_issue(1'b1, 11'h020, 8'h22);
    for (int i = 0; i < 40 && s2_ph < 0; i++) begin
      step();
      if (bus_if.vram_n_we === 1'b0 && bus_if.vram_addr === 11'h010) s1_ph = int'(char_pix_count);
      if (bus_if.vram_n_we === 1'b0 && bus_if.vram_addr === 11'h020) s2_ph = int'(char_pix_count);
      if (bus_if.cpu_ack === 1'b1 && ack2_ph < 0) begin
        ack2_ph = int'(char_pix_count);
        ack2_after_s1 = (s1_ph >= 0) ? 1 : 0;
        cpu_idle();
      end
    end
    vectors++; if (s1_ph != 9) begin miscompares++; $display("[TB] FAIL b2b_drain1_phase: got=%0d want=9", s1_ph); end
    vectors++; if (ack2_after_s1 != 1) begin miscompares++; $display("[TB] FAIL b2b_second_stalled: got=%0d want=1", ack2_after_s1); end
    vectors++; if (ack2_ph != 2) begin miscompares++; $display("[TB] FAIL b2b_second_ack_phase: got=%0d want=2", ack2_ph); end
    vectors++; if (s2_ph != 9) begin miscompares++; $display("[TB] FAIL b2b_drain2_phase: got=%0d want=9", s2_ph); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_idle();
    test_read_window();
    test_crtc_capture();
    test_closed_phase();
    test_reset_strobe();
    test_no_strobe_random();
`ifdef VRAM_ARB_WRITE_BUFFER_EN
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
